uart_rx_frame: RTL and testbench
================================

# uart_rx_frame

Oversampling UART receiver: deserializes 8-bit frames (start, 8 data LSB-first, optional parity, 1 stop) arriving on the serial line into bytes for the system's command path. It sits in the UART clock domain and hands each byte plus error flags to the data synchronizer. It is the receive counterpart of the system's UART transmitter and matches its framing exactly: idle-high line, 11-bit frame with parity enabled.

## Interface
- `DATA_WIDTH`, 8, payload bits per frame
- `PRESCALE_WIDTH`, 6, width of the oversampling ratio input
- `i_uart_clk`  in  1  oversampling clock (3.6864 MHz nominal)
- `i_arst_n`  in  1  reset; asynchronous assert, active-low (one clock; reset is asynchronous and active-low)
- `i_rx_in`  in  1  serial line, asynchronous to `i_uart_clk`, idle high
- `i_prescale`  in  PRESCALE_WIDTH  oversampling ratio P; legal values are even integers 8..32 (32 gives 115200 baud)
- `i_par_en`  in  1  1 = parity bit present
- `i_par_typ`  in  1  0 = even, 1 = odd
- `o_data`  out  DATA_WIDTH  last correctly received byte
- `o_data_valid`  out  1  one-cycle pulse, `o_data` updated
- `o_par_err`  out  1  one-cycle pulse, parity mismatch
- `o_stp_err`  out  1  one-cycle pulse, stop bit sampled 0

## Operation
- `i_rx_in` passes through a 2-FF synchronizer (reset value 1); all logic uses the synchronized value `rx_s`.
- `i_prescale`, `i_par_en`, and `i_par_typ` are latched on start-edge detection and held for the whole frame.
- Counters:
  - `edge_cnt` runs 0..P-1 and wraps.
  - `bit_cnt` counts data bits 0..DATA_WIDTH-1.
- Each bit is sampled at `edge_cnt` = P/2-1, P/2, and P/2+1. The bit value is the 2-of-3 majority, registered at `edge_cnt` = P/2+2.
- States:
  - IDLE: on `rx_s` = 0, go to START with `edge_cnt` = 0.
  - START: at the decision point, majority 1 (glitch) → IDLE, no outputs; majority 0 → continue to end of bit, then DATA.
  - DATA: shift majority into the shift register MSB, shifting right (LSB-first line order). After bit DATA_WIDTH-1 ends → PARITY if `i_par_en`, else STOP.
  - PARITY: compare majority with XOR(data) ^ `i_par_typ`; store the mismatch flag. At end of bit → STOP.
  - STOP: at the decision point, evaluate the frame (see below), then → IDLE immediately. Returning mid-stop-bit lets a following start edge be caught without loss.
- Frame evaluation at the STOP decision point:
  - `o_stp_err` = (majority == 0).
  - `o_par_err` = stored mismatch.
  - If neither error: `o_data` ← shift register and pulse `o_data_valid`.
  - On any error, `o_data` is unchanged and `o_data_valid` stays 0.
- Reset values:
  - `o_data` = 0, all pulse outputs = 0.
  - State IDLE, counters 0, synchronizer = 1.
- Asserting reset mid-frame aborts immediately with no outputs. After release the block waits in IDLE for the next falling edge. A line already low at release is treated as a start bit.
- Line held low: gives a stop error, then the block re-enters IDLE and sees `rx_s` = 0 as a new start. Repeats every frame time.

## Timing
- Start detection: 2 cycles of synchronizer latency after the `i_rx_in` fall; the IDLE→START transition occurs on that cycle.
- Output pulses are registered. They rise one cycle after the STOP decision point, i.e. (1+DATA_WIDTH+par_en)·P + P/2 + 3 cycles after START entry (plus the 2-cycle synchronizer latency from the line edge).
- Pulses are exactly 1 cycle wide. They are never asserted in two consecutive cycles.
- Back-to-back frames at exactly P·(10+par_en) cycles per frame are received without loss.
- Tolerates ±(P/2-2)/P·(1/frame bits) clock drift.
- No backpressure: the consumer must accept `o_data` on the `o_data_valid` cycle; `o_data` holds until the next good frame.

## Structure
- `uart_pkg`:
  - `rx_state_e` enum (IDLE, START, DATA, PARITY, STOP).
  - `PAR_EVEN`/`PAR_ODD` constants.
  - `parity_calc` function, shared with the transmitter.
- Sub-module `uart_rx_sampler`: owns `edge_cnt`, the 3-point sampling, and the majority register; exports `bit_val`, `bit_decide` and `bit_end` strobes. The top holds the FSM, shift register, and output registers.

## Test plan
- P=32, parity even: send 0xA5 (parity 0, stop 1) → single `o_data_valid` pulse, `o_data`=0xA5, no errors.
- P=32, parity even: send 0x3C with parity bit 1 → `o_par_err` pulse, no valid, `o_data` keeps the previous value 0xA5.
- P=16, parity off: send 0x81 with stop bit 0 → `o_stp_err` pulse only. The block recovers and receives a following 0x7E correctly.
- P=32: 5-cycle low glitch on an idle line → no pulses; state returns to IDLE; the next real 0x55 frame is received.
- P=32: back-to-back 0x55, 0xAA, 0x00 with no idle gap → three valid pulses, in order; assert reset mid-second frame in a repeat run → all outputs 0, the remainder of that frame ignored, and the next full frame is received.
- P=8, odd parity: random 200 bytes with ±2% baud drift → all received, zero errors.

Source files
------------

// File: rtl/uart_rx_frame_pkg.sv
// Shared UART definitions: receiver state encoding, parity selection and helpers
// used by both the receiver and the transmitter.
`timescale 1ps/1ps
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Wide enough for any payload; zero-extension does not change the XOR.
  localparam int PARITY_MAX_WIDTH = 32;

  function automatic logic parity_calc(input logic [PARITY_MAX_WIDTH-1:0] data,
                                       input logic par_typ);
    return (par_typ == PAR_EVEN) ? (^data) : ~(^data);
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_frame_if.sv
// Receive-side output bundle: the received byte plus its one-cycle status pulses.
`timescale 1ps/1ps
interface uart_rx_frame_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_data_valid;
  logic                  o_par_err;
  logic                  o_stp_err;

  modport master (output o_data, output o_data_valid, output o_par_err, output o_stp_err);
  modport slave  (input  o_data, input  o_data_valid, input  o_par_err, input  o_stp_err);
endinterface

// File: rtl/uart_rx_frame_sampler.sv
// Bit timing for the receiver: oversampling edge counter, 3-point sampling around
// mid-bit and a registered 2-of-3 majority, with decision and end-of-bit strobes.
`timescale 1ps/1ps
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_rx_s,
  input  logic [PRESCALE_WIDTH-1:0] i_prescale,
  input  logic                      i_cnt_en,
  output logic                      o_bit_val,
  output logic                      o_bit_decide,
  output logic                      o_bit_end
);
  localparam logic [PRESCALE_WIDTH-1:0] CNT_ONE = PRESCALE_WIDTH'(1);
  localparam logic [PRESCALE_WIDTH-1:0] CNT_TWO = PRESCALE_WIDTH'(2);

  logic [PRESCALE_WIDTH-1:0] r_edge_cnt;
  logic [1:0]                r_samples;
  logic                      r_bit_val;
  logic [PRESCALE_WIDTH-1:0] w_half;

  assign w_half       = i_prescale >> 1;
  assign o_bit_end    = (r_edge_cnt == i_prescale - CNT_ONE);
  assign o_bit_decide = (r_edge_cnt == w_half + CNT_TWO);
  assign o_bit_val    = r_bit_val;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_edge_cnt <= '0;
      r_samples  <= 2'b11;
      r_bit_val  <= 1'b1;
    end else begin
      // Counter parks at 0 whenever the FSM is (or is about to be) idle.
      if (i_cnt_en && !o_bit_end)
        r_edge_cnt <= r_edge_cnt + CNT_ONE;
      else
        r_edge_cnt <= '0;

      if (r_edge_cnt == w_half - CNT_ONE)
        r_samples[0] <= i_rx_s;
      if (r_edge_cnt == w_half)
        r_samples[1] <= i_rx_s;
      if (r_edge_cnt == w_half + CNT_ONE)
        r_bit_val <= majority3(r_samples[0], r_samples[1], i_rx_s);
    end
  end

endmodule

// File: rtl/uart_rx_frame.sv
// Oversampling UART receiver: start, DATA_WIDTH data bits LSB-first, optional
// parity and one stop bit; delivers the byte and error pulses.
//   state  | meaning
//   IDLE   | line idle, waiting for rx_s = 0
//   START  | validating start bit; majority 1 is a glitch
//   DATA   | shifting in data bits
//   PARITY | checking the parity bit
//   STOP   | evaluating stop bit, then straight back to IDLE
`timescale 1ps/1ps
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      i_uart_clk,
  input  logic                      i_arst_n,
  input  logic                      i_rx_in,
  input  logic [PRESCALE_WIDTH-1:0] i_prescale,
  input  logic                      i_par_en,
  input  logic                      i_par_typ,
  uart_rx_frame_if.master           o_rx
);
  localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [1:0]                r_sync;
  rx_state_e                 r_state;
  rx_state_e                 w_state_next;
  logic [PRESCALE_WIDTH-1:0] r_prescale;
  logic                      r_par_en;
  logic                      r_par_typ;
  logic [DATA_WIDTH-1:0]     r_shift;
  logic [BIT_CNT_W-1:0]      r_bit_cnt;
  logic                      r_par_mis;

  logic w_rx_s;
  logic w_bit_val;
  logic w_bit_decide;
  logic w_bit_end;
  logic w_bit_last;
  logic w_cnt_en;
  logic w_start_det;
  logic w_shift_en;
  logic w_par_chk;
  logic w_frame_done;

  assign w_rx_s     = r_sync[1];
  assign w_bit_last = (r_bit_cnt == BIT_CNT_W'(DATA_WIDTH - 1));
  assign w_cnt_en   = (r_state != IDLE) && (w_state_next != IDLE);

  uart_rx_sampler #(
    .PRESCALE_WIDTH (PRESCALE_WIDTH)
  ) u_sampler (
    .i_clk        (i_uart_clk),
    .i_rst_n      (i_arst_n),
    .i_rx_s       (w_rx_s),
    .i_prescale   (r_prescale),
    .i_cnt_en     (w_cnt_en),
    .o_bit_val    (w_bit_val),
    .o_bit_decide (w_bit_decide),
    .o_bit_end    (w_bit_end)
  );

  always_ff @(posedge i_uart_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_sync  <= 2'b11;
      r_state <= IDLE;
    end else begin
      r_sync  <= {r_sync[0], i_rx_in};
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_start_det  = 1'b0;
    w_shift_en   = 1'b0;
    w_par_chk    = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_rx_s) begin
          w_state_next = START;
          w_start_det  = 1'b1;
        end
      end
      START: begin
        if (w_bit_decide && w_bit_val)
          w_state_next = IDLE;
        else if (w_bit_end)
          w_state_next = DATA;
      end
      DATA: begin
        w_shift_en = w_bit_decide;
        if (w_bit_end && w_bit_last)
          w_state_next = r_par_en ? PARITY : STOP;
      end
      PARITY: begin
        w_par_chk = w_bit_decide;
        if (w_bit_end)
          w_state_next = STOP;
      end
      STOP: begin
        if (w_bit_decide) begin
          w_frame_done = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_uart_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_prescale <= '0;
      r_par_en   <= 1'b0;
      r_par_typ  <= PAR_EVEN;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_par_mis  <= 1'b0;
    end else begin
      if (w_start_det) begin
        r_prescale <= i_prescale;
        r_par_en   <= i_par_en;
        r_par_typ  <= i_par_typ;
        r_bit_cnt  <= '0;
        r_par_mis  <= 1'b0;
      end
      if (w_shift_en)
        r_shift <= {w_bit_val, r_shift[DATA_WIDTH-1:1]};
      if ((r_state == DATA) && w_bit_end)
        r_bit_cnt <= w_bit_last ? '0 : r_bit_cnt + BIT_CNT_W'(1);
      if (w_par_chk)
        r_par_mis <= (w_bit_val != parity_calc(PARITY_MAX_WIDTH'(r_shift), r_par_typ));
    end
  end

  always_ff @(posedge i_uart_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      o_rx.o_data       <= '0;
      o_rx.o_data_valid <= 1'b0;
      o_rx.o_par_err    <= 1'b0;
      o_rx.o_stp_err    <= 1'b0;
    end else begin
      o_rx.o_data_valid <= 1'b0;
      o_rx.o_par_err    <= 1'b0;
      o_rx.o_stp_err    <= 1'b0;
      if (w_frame_done) begin
        o_rx.o_stp_err <= ~w_bit_val;
        o_rx.o_par_err <= r_par_mis;
        if (w_bit_val && !r_par_mis) begin
          o_rx.o_data       <= r_shift;
          o_rx.o_data_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: directed frame table, multi-cycle corner
// sequences, and randomized frames scored against a frame-level reference model.
`timescale 1ps/1ps
module tb_uart_rx_frame;
  localparam int CYC = 10000;

  typedef struct {
    int         p;
    logic       pe;
    logic       ptyp;
    logic [7:0] d;
    logic       pbit;
    logic       stop;
    logic       xv;
    logic       xpe;
    logic       xse;
    logic [7:0] xd;
  } vec_t;

  typedef struct {
    logic       v;
    logic       pe;
    logic       se;
    logic [7:0] d;
    int         cyc;
  } evt_t;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       rx       = 1'b1;
  logic [5:0] prescale = 6'd32;
  logic       par_en   = 1'b1;
  logic       par_typ  = 1'b0;

  uart_rx_frame_if #(.DATA_WIDTH(8)) rx_if ();

  uart_rx_frame #(
    .DATA_WIDTH     (8),
    .PRESCALE_WIDTH (6)
  ) dut (
    .i_uart_clk (clk),
    .i_arst_n   (rst_n),
    .i_rx_in    (rx),
    .i_prescale (prescale),
    .i_par_en   (par_en),
    .i_par_typ  (par_typ),
    .o_rx       (rx_if)
  );

  always #(CYC/2) clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   ev_rd    = 0;
  evt_t evq[$];

  // Pulse recorder: every cycle carrying any output pulse becomes one event.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rx_if.o_data_valid || rx_if.o_par_err || rx_if.o_stp_err)
      evq.push_back('{rx_if.o_data_valid, rx_if.o_par_err, rx_if.o_stp_err, rx_if.o_data, cyc});
  end

  // Required parity bit from the framing rules: even -> total ones even, odd -> odd.
  function automatic logic req_parity(input logic [7:0] d, input logic ptyp);
    int ones;
    ones = $countones(d);
    if (ptyp)
      return ((ones % 2) == 0);
    else
      return ((ones % 2) == 1);
  endfunction

  task automatic send_frame(input logic [7:0] d, input int p, input logic pe, input logic ptyp,
                            input logic pbit, input logic stop, input int bit_ps);
    prescale = 6'(p);
    par_en   = pe;
    par_typ  = ptyp;
    rx = 1'b0;
    #(bit_ps);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      #(bit_ps);
    end
    if (pe) begin
      rx = pbit;
      #(bit_ps);
    end
    rx = stop;
    #(bit_ps);
    rx = 1'b1;
  endtask

  task automatic check_count(input string name, input int exp_n);
    int got;
    got = evq.size() - ev_rd;
    n_checks++;
    if (got != exp_n) begin
      n_fail++;
      $display("FAIL %s count: got %0d pulse events, expected %0d", name, got, exp_n);
    end
  endtask

  task automatic check_next(input string name, input logic xv, input logic xpe, input logic xse,
                            input logic [7:0] xd);
    evt_t e;
    n_checks++;
    if (ev_rd >= evq.size()) begin
      n_fail++;
      $display("FAIL %s event: got no pulse, expected v/pe/se=%b%b%b data=%h", name, xv, xpe, xse, xd);
    end else begin
      e = evq[ev_rd];
      if (e.v !== xv || e.pe !== xpe || e.se !== xse || (xv && e.d !== xd)) begin
        n_fail++;
        $display("FAIL %s event: got v/pe/se=%b%b%b data=%h, expected v/pe/se=%b%b%b data=%h",
                 name, e.v, e.pe, e.se, e.d, xv, xpe, xse, xd);
      end
      if (ev_rd > 0) begin
        n_checks++;
        if (e.cyc == evq[ev_rd-1].cyc + 1) begin
          n_fail++;
          $display("FAIL %s spacing: got pulses in adjacent cycles %0d and %0d, expected a gap",
                   name, evq[ev_rd-1].cyc, e.cyc);
        end
      end
      ev_rd++;
    end
  endtask

  task automatic check_data(input string name, input logic [7:0] xd);
    n_checks++;
    if (rx_if.o_data !== xd) begin
      n_fail++;
      $display("FAIL %s data: got %h, expected %h", name, rx_if.o_data, xd);
    end
  endtask

  task automatic check_pulses_low(input string name);
    n_checks++;
    if ({rx_if.o_data_valid, rx_if.o_par_err, rx_if.o_stp_err} !== 3'b000) begin
      n_fail++;
      $display("FAIL %s pulses: got v/pe/se=%b%b%b, expected 000", name,
               rx_if.o_data_valid, rx_if.o_par_err, rx_if.o_stp_err);
    end
  endtask

  task automatic check_frame(input string name, input logic xv, input logic xpe, input logic xse,
                             input logic [7:0] xd);
    check_count(name, 1);
    check_next(name, xv, xpe, xse, xd);
    check_data(name, xd);
    ev_rd = evq.size();
  endtask

  vec_t       vecs[9];
  logic [7:0] model_data;
  int         p, drift;
  logic       pe, ptyp, pbit, stop, req, xv, xpe, xse;
  logic [7:0] d;

  initial begin
    //           p   pe    ptyp  data   pbit  stop   xv    xpe   xse   xdata
    vecs[0] = '{32, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5};
    vecs[1] = '{32, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5};
    vecs[2] = '{16, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5};
    vecs[3] = '{16, 1'b0, 1'b0, 8'h7E, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h7E};
    vecs[4] = '{ 8, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[5] = '{ 8, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[6] = '{20, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00};
    vecs[7] = '{32, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hC3};
    vecs[8] = '{10, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h01};

    repeat (3) @(negedge clk);
    check_data("reset", 8'h00);
    check_pulses_low("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      send_frame(vecs[i].d, vecs[i].p, vecs[i].pe, vecs[i].ptyp, vecs[i].pbit, vecs[i].stop,
                 vecs[i].p * CYC);
      #(2 * vecs[i].p * CYC);
      check_frame($sformatf("vec%0d", i), vecs[i].xv, vecs[i].xpe, vecs[i].xse, vecs[i].xd);
    end

    // Short low glitch on an idle line, then a real frame.
    @(negedge clk);
    prescale = 6'd32; par_en = 1'b1; par_typ = 1'b0;
    rx = 1'b0;
    #(5 * CYC);
    rx = 1'b1;
    #(64 * CYC);
    check_count("glitch", 0);
    ev_rd = evq.size();
    send_frame(8'h55, 32, 1'b1, 1'b0, 1'b0, 1'b1, 32 * CYC);
    #(64 * CYC);
    check_frame("after_glitch", 1'b1, 1'b0, 1'b0, 8'h55);

    // Back-to-back frames with no idle gap.
    @(negedge clk);
    send_frame(8'h55, 32, 1'b1, 1'b0, 1'b0, 1'b1, 32 * CYC);
    send_frame(8'hAA, 32, 1'b1, 1'b0, 1'b0, 1'b1, 32 * CYC);
    send_frame(8'h00, 32, 1'b1, 1'b0, 1'b0, 1'b1, 32 * CYC);
    #(64 * CYC);
    check_count("b2b", 3);
    check_next("b2b_0", 1'b1, 1'b0, 1'b0, 8'h55);
    check_next("b2b_1", 1'b1, 1'b0, 1'b0, 8'hAA);
    check_next("b2b_2", 1'b1, 1'b0, 1'b0, 8'h00);
    check_data("b2b", 8'h00);
    ev_rd = evq.size();

    // Same run with reset asserted mid-way through the second frame.
    @(negedge clk);
    send_frame(8'h55, 32, 1'b1, 1'b0, 1'b0, 1'b1, 32 * CYC);
    fork
      send_frame(8'hAA, 32, 1'b1, 1'b0, 1'b0, 1'b1, 32 * CYC);
      begin
        #(5 * 32 * CYC);
        rst_n = 1'b0;
        #(3 * CYC);
        check_data("rst_mid_during", 8'h00);
        check_pulses_low("rst_mid_during");
        #(5 * 32 * CYC + 5 * CYC);
        rst_n = 1'b1;
      end
    join
    send_frame(8'hC3, 32, 1'b1, 1'b0, 1'b0, 1'b1, 32 * CYC);
    #(64 * CYC);
    check_count("rst_mid", 2);
    check_next("rst_mid_0", 1'b1, 1'b0, 1'b0, 8'h55);
    check_next("rst_mid_1", 1'b1, 1'b0, 1'b0, 8'hC3);
    check_data("rst_mid", 8'hC3);
    ev_rd = evq.size();

    // Line stuck low: a stop error every frame time, data untouched.
    @(negedge clk);
    prescale = 6'd16; par_en = 1'b0; par_typ = 1'b0;
    rx = 1'b0;
    #(330 * CYC);
    check_data("stuck_low_hold", 8'hC3);
    rst_n = 1'b0;
    #(2 * CYC);
    rx = 1'b1;
    #(2 * CYC);
    rst_n = 1'b1;
    #(8 * CYC);
    check_count("stuck_low", 2);
    check_next("stuck_low_0", 1'b0, 1'b0, 1'b1, 8'h00);
    check_next("stuck_low_1", 1'b0, 1'b0, 1'b1, 8'h00);
    check_data("stuck_low_after_rst", 8'h00);
    ev_rd = evq.size();
    model_data = 8'h00;

    // Random frames with random prescale/parity and injected faults.
    for (int i = 0; i < 60; i++) begin
      p    = 8 + 2 * int'($urandom_range(0, 12));
      pe   = 1'($urandom_range(0, 1));
      ptyp = 1'($urandom_range(0, 1));
      d    = 8'($urandom_range(0, 255));
      req  = req_parity(d, ptyp);
      pbit = ($urandom_range(0, 3) == 0) ? ~req : req;
      stop = ($urandom_range(0, 7) != 0);
      xpe  = pe && (pbit != req);
      xse  = !stop;
      xv   = !xpe && !xse;
      if (xv) model_data = d;
      @(negedge clk);
      send_frame(d, p, pe, ptyp, pbit, stop, p * CYC);
      #(2 * p * CYC);
      check_frame($sformatf("rand%0d", i), xv, xpe, xse, model_data);
    end

    // P=8, odd parity, per-frame baud drift within +/-2%.
    for (int i = 0; i < 200; i++) begin
      d     = 8'($urandom_range(0, 255));
      drift = int'($urandom_range(0, 40)) - 20;
      @(negedge clk);
      send_frame(d, 8, 1'b1, 1'b1, req_parity(d, 1'b1), 1'b1, (8 * CYC * (1000 + drift)) / 1000);
      #(16 * CYC);
      model_data = d;
      check_frame($sformatf("drift%0d", i), 1'b1, 1'b0, 1'b0, model_data);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
